// File: rtl/wb_per_bridge.sv
// Wishbone-classic slave bridging 32-bit bus cycles onto a 16-bit openMSP430-style
// peripheral bus; each word access becomes one or two halfword peripheral cycles.
module wb_per_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [13:0] per_addr_o,
  output logic [15:0] per_din_o,
  output logic        per_en_o,
  output logic [1:0]  per_we_o,
  input  logic [15:0] per_dout_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [12:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        need_hi_q, need_hi_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  sel_eff;
  logic        hit;
  logic        per_en_d;
  logic [13:0] per_addr_d;
  logic [15:0] per_din_d;
  logic [1:0]  per_we_d;
  logic        ack_d;
  logic [31:0] dat_o_d;

  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    need_hi_d = need_hi_q;
    rdata_d   = rdata_q;
    sel_eff   = (!wbs_we_i && wbs_sel_i == 4'b0000) ? 4'b1111 : wbs_sel_i;
    hit       = (wbs_adr_i[31:15] == BASE_ADDR[31:15]);

    case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          adr_d     = wbs_adr_i[14:2];
          dat_d     = wbs_dat_i;
          sel_d     = sel_eff;
          we_d      = wbs_we_i;
          need_hi_d = |sel_eff[3:2];
          rdata_d   = '0;
          if (!hit)                 state_d = S_ACK;
          else if (|sel_eff[1:0])   state_d = S_LO;
          else if (|sel_eff[3:2])   state_d = S_HI;
          else                      state_d = S_ACK;
        end
      end
      S_LO: begin
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          if (!we_q) rdata_d[15:0] = per_dout_i;
          state_d = need_hi_q ? S_HI : S_ACK;
        end
      end
      S_HI: begin
        if (!wbs_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          if (!we_q) rdata_d[31:16] = per_dout_i;
          state_d = S_ACK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    per_en_d   = (state_d == S_LO) || (state_d == S_HI);
    per_addr_d = per_en_d ? {adr_d, (state_d == S_HI)} : '0;
    per_din_d  = '0;
    per_we_d   = '0;
    if (state_d == S_LO) begin
      per_din_d = dat_d[15:0];
      per_we_d  = we_d ? sel_d[1:0] : 2'b00;
    end else if (state_d == S_HI) begin
      per_din_d = dat_d[31:16];
      per_we_d  = we_d ? sel_d[3:2] : 2'b00;
    end
    ack_d   = (state_d == S_ACK);
    dat_o_d = ack_d ? rdata_d : '0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= S_IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      need_hi_q  <= 1'b0;
      rdata_q    <= '0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      per_addr_o <= '0;
      per_din_o  <= '0;
      per_en_o   <= 1'b0;
      per_we_o   <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      need_hi_q  <= need_hi_d;
      rdata_q    <= rdata_d;
      wbs_ack_o  <= ack_d;
      wbs_dat_o  <= dat_o_d;
      per_addr_o <= per_addr_d;
      per_din_o  <= per_din_d;
      per_en_o   <= per_en_d;
      per_we_o   <= per_we_d;
    end
  end

endmodule

// File: tb/tb_wb_per_bridge.sv
// Self-checking bench for wb_per_bridge: directed scenarios plus random transactions
// checked cycle by cycle against a halfword-access list built from the bridge rules.
module tb_wb_per_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack;
  logic [31:0] dat_o;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_per_bridge #(.BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat),
    .wbs_ack_o (ack),
    .wbs_dat_o (dat_o),
    .per_addr_o(per_addr),
    .per_din_o (per_din),
    .per_en_o  (per_en),
    .per_we_o  (per_we),
    .per_dout_i(per_dout)
  );

  task automatic go_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat = '0; per_dout = '0;
  endtask

  // Drive one transaction (called at a negedge) and check every following cycle.
  // lead = cycles before the bridge samples the request (1 when issued during ACK).
  // rd_src supplies per_dout for the low/high halfword reads.
  task automatic run_txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] rd_src,
                         input int lead, input string nm);
    logic [3:0]  es;
    logic        hit;
    int          n;
    logic [13:0] ea[2];
    logic [15:0] ed[2];
    logic [1:0]  ew[2];
    logic        eh[2];
    logic [31:0] exp_rd;
    int          j;
    hit = (a[31:15] == BASE[31:15]);
    es  = (!w && s == 4'b0000) ? 4'b1111 : s;
    n   = 0;
    if (hit && (es[1:0] != 2'b00)) begin
      ea[n] = a[14:2] * 2; ed[n] = d[15:0];  ew[n] = w ? es[1:0] : 2'b00; eh[n] = 1'b0; n++;
    end
    if (hit && (es[3:2] != 2'b00)) begin
      ea[n] = a[14:2] * 2 + 1; ed[n] = d[31:16]; ew[n] = w ? es[3:2] : 2'b00; eh[n] = 1'b1; n++;
    end
    exp_rd = '0;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; dat = d;
    for (int k = 1; k <= lead + n + 1; k++) begin
      @(negedge clk);
      j = k - lead;
      if (j >= 1 && j <= n) begin
        tests++;
        if (per_en !== 1'b1) begin fails++; $display("FAIL %s per_en c%0d got %b want 1", nm, j, per_en); end
        tests++;
        if (per_addr !== ea[j-1]) begin fails++; $display("FAIL %s per_addr c%0d got %h want %h", nm, j, per_addr, ea[j-1]); end
        tests++;
        if (per_din !== ed[j-1]) begin fails++; $display("FAIL %s per_din c%0d got %h want %h", nm, j, per_din, ed[j-1]); end
        tests++;
        if (per_we !== ew[j-1]) begin fails++; $display("FAIL %s per_we c%0d got %b want %b", nm, j, per_we, ew[j-1]); end
        per_dout = eh[j-1] ? rd_src[31:16] : rd_src[15:0];
        if (!w) begin
          if (eh[j-1]) exp_rd[31:16] = per_dout;
          else         exp_rd[15:0]  = per_dout;
        end
      end else begin
        per_dout = 16'($urandom);
        tests++;
        if (per_en !== 1'b0 || per_we !== 2'b00 || per_din !== 16'h0) begin
          fails++; $display("FAIL %s idle_per c%0d got en=%b we=%b din=%h want 0", nm, j, per_en, per_we, per_din);
        end
      end
      tests++;
      if (ack !== (j == n + 1)) begin fails++; $display("FAIL %s ack c%0d got %b want %b", nm, j, ack, (j == n + 1)); end
      if (j == n + 1) begin
        tests++;
        if (dat_o !== exp_rd) begin fails++; $display("FAIL %s dat_o got %h want %h", nm, dat_o, exp_rd); end
      end
    end
  endtask

  task automatic check_all_zero(input string nm);
    tests++;
    if (ack !== 1'b0 || dat_o !== 32'h0 || per_addr !== 14'h0 || per_din !== 16'h0 ||
        per_en !== 1'b0 || per_we !== 2'b00) begin
      fails++;
      $display("FAIL %s outputs got ack=%b dat=%h addr=%h din=%h en=%b we=%b want all 0",
               nm, ack, dat_o, per_addr, per_din, per_en, per_we);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    go_idle();
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_full_write();
    run_txn(32'h3000_0010, 1'b1, 4'hF, 32'hBEEF_1234, 32'h0, 0, "full_write");
    go_idle();
    @(negedge clk);
  endtask

  task automatic test_full_read();
    run_txn(32'h3000_0010, 1'b0, 4'hF, 32'h0, 32'hAAAA_5555, 0, "full_read");
    go_idle();
    @(negedge clk);
    run_txn(32'h3000_7FFC, 1'b0, 4'h0, 32'h0, 32'h1357_9BDF, 0, "read_sel0");
    go_idle();
    @(negedge clk);
  endtask

  task automatic test_partial();
    run_txn(32'h3000_0020, 1'b1, 4'b0100, 32'h00CD_0000, 32'h0, 0, "byte_write_hi");
    go_idle(); @(negedge clk);
    run_txn(32'h3000_0024, 1'b1, 4'b0010, 32'h0000_AB00, 32'h0, 0, "byte_write_lo");
    go_idle(); @(negedge clk);
    run_txn(32'h3000_0028, 1'b0, 4'b1000, 32'h0, 32'h7777_8888, 0, "byte_read_hi");
    go_idle(); @(negedge clk);
    run_txn(32'h3000_0030, 1'b1, 4'b0000, 32'hFFFF_FFFF, 32'h0, 0, "write_sel0");
    go_idle(); @(negedge clk);
  endtask

  task automatic test_miss();
    run_txn(32'h3001_0000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, "miss_read");
    go_idle(); @(negedge clk);
    run_txn(32'h2FFF_FFFC, 1'b1, 4'hF, 32'h1234_5678, 32'h0, 0, "miss_write");
    go_idle(); @(negedge clk);
  endtask

  task automatic test_abort();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0040; dat = '0;
    @(negedge clk);
    tests++;
    if (per_en !== 1'b1 || per_addr !== 14'h0020) begin
      fails++; $display("FAIL abort_t1 got en=%b addr=%h want en=1 addr=0020", per_en, per_addr);
    end
    per_dout = 16'h4321;
    cyc = 1'b0; stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (per_en !== 1'b0 || ack !== 1'b0) begin
        fails++; $display("FAIL abort_after c%0d got en=%b ack=%b want 0 0", k + 2, per_en, ack);
      end
    end
    go_idle();
    run_txn(32'h3000_0044, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 0, "after_abort");
    go_idle(); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0100; dat = 32'hCAFE_D00D;
    repeat (2) @(negedge clk);
    tests++;
    if (per_en !== 1'b1 || per_addr !== 14'h0081) begin
      fails++; $display("FAIL rst_mid_hi got en=%b addr=%h want en=1 addr=0081", per_en, per_addr);
    end
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_mid_async");
    go_idle();
    @(negedge clk);
    check_all_zero("rst_mid_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid_release");
    run_txn(32'h3000_0100, 1'b0, 4'hF, 32'h0, 32'h1111_2222, 0, "after_reset");
    go_idle(); @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_txn(32'h3002_0000, 1'b0, 4'hF, 32'h0, 32'h0, 0, "b2b_miss0");
    run_txn(32'h3003_0000, 1'b1, 4'hF, 32'h0, 32'h0, 1, "b2b_miss1");
    run_txn(32'h3000_0200, 1'b0, 4'hF, 32'h0, 32'h5A5A_A5A5, 1, "b2b_full");
    run_txn(32'h3000_0204, 1'b1, 4'b0011, 32'h9999_6666, 32'h0, 1, "b2b_lo");
    go_idle(); @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a = {BASE[31:15], a[14:0]};
      run_txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom,
              0, "random");
      if ($urandom_range(0, 2) == 0) begin
        a = {BASE[31:15], 15'($urandom)};
        run_txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom, 1, "random_b2b");
      end
      go_idle();
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    go_idle();
    test_reset();
    test_full_write();
    test_full_read();
    test_partial();
    test_miss();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_per_bridge.md
# wb_per_bridge

Wishbone-classic slave that converts 32-bit Caravel user-area bus cycles into openMSP430-style 16-bit peripheral-bus cycles (per_addr/per_din/per_en/per_we/per_dout) for openGFX430. It sits directly upstream of the graphics controller in user_project_wrapper. Each 32-bit access is split into one or two sequential 16-bit peripheral accesses, with read data assembled and a registered acknowledge returned.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, byte base of the peripheral window; only bits [31:15] are compared.

Ports:
- wb_clk_i  in  1  single clock for bus and peripheral side
- wb_rst_n  in  1  asynchronous, active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write (1) / read (0)
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  registered one-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack
- per_addr_o  out  14  peripheral word address
- per_din_o  out  16  peripheral write data
- per_en_o  out  1  peripheral enable, one cycle per halfword access
- per_we_o  out  2  byte write enables {hi, lo}; 2'b00 = read
- per_dout_i  in  16  peripheral read data, combinational in the per_en_o cycle

## Operation
- All outputs registered; reset value 0 for every output. FSM resets to IDLE.
- FSM states: IDLE, LO, HI, ACK.
- IDLE: on cyc&stb, latch adr, dat, sel, we. Window hit = adr[31:15]==BASE_ADDR[31:15].
  - Miss -> ACK with wbs_dat_o=0; no peripheral cycle.
  - Hit, write: need_lo = |sel[1:0], need_hi = |sel[3:2]. Neither -> ACK directly (no peripheral cycle).
  - Hit, read: need_lo/need_hi as above; sel==4'b0000 on read is treated as 4'b1111.
  - Go to LO if need_lo, else HI.
- LO: per_en_o=1, per_addr_o={adr[14:2],1'b0}, per_din_o=dat[15:0], per_we_o = we ? sel[1:0] : 2'b00. At edge ending LO: capture per_dout_i into rdata[15:0] on read; next HI if need_hi, else ACK.
- HI: per_en_o=1, per_addr_o={adr[14:2],1'b1}, per_din_o=dat[31:16], per_we_o = we ? sel[3:2] : 2'b00. Capture per_dout_i into rdata[31:16] on read; next ACK.
- ACK: wbs_ack_o=1 for exactly one cycle, wbs_dat_o=rdata (halves not accessed read as 0; writes return 0); next IDLE.
- rdata cleared at transaction start.
- Abort: cyc_i low while in LO or HI -> next state IDLE, per_en_o deasserts next cycle, no ack; halfword writes already issued are not undone. stb is only sampled in IDLE.
- per_en_o is never high in IDLE or ACK; per_we_o/per_din_o return to 0 when per_en_o is low.

## Timing
- T0: cyc&stb sampled high in IDLE.
- Full word (both halves): per_en_o high in T1 (lo) and T2 (hi); ack in T3.
- Single half: per_en_o in T1; ack in T2.
- Miss or write with sel==0: ack in T1.
- Back-to-back: IDLE re-samples stb in the cycle after ACK; a master holding stb high with a new address starts a new transaction there. Minimum spacing between acks: 2 cycles.
- Reset asserted mid-transaction: all outputs go to 0 immediately (async), FSM returns to IDLE, and the transaction is dropped.

## Test plan
- Full-word write: adr=0x3000_0010, sel=4'hF, dat=0xBEEF_1234 -> T1: per_addr=0x0008, we=2'b11, din=0x1234; T2: per_addr=0x0009, din=0xBEEF; ack in T3.
- Full-word read: per_dout=0x5555 in T1 and 0xAAAA in T2 -> wbs_dat_o=0xAAAA_5555 with ack in T3.
- Byte write: sel=4'b0100, dat=0x00CD_0000 -> single per_en in T1 with per_addr odd, we=2'b01, din=0x00CD; ack in T2.
- Out-of-window read at adr=0x3001_0000 -> no per_en; ack in T1 with data 0.
- Abort: drop cyc in T1 of a full-word read -> per_en seen only in T1; no ack; FSM in IDLE at T2.
- Reset: assert wb_rst_n=0 during HI -> per_en_o, wbs_ack_o and all outputs go to 0 asynchronously; the first access after release completes normally.
